// File: rtl/place_pkg.sv
// place_pkg: state encoding and default sizing shared by place_eval and the placement engine.
package place_pkg;
    typedef enum logic [2:0] {IDLE, S_EDGE, S_PA, S_PB, S_DIFF, S_ACC, DONE, ERROR} state_e;
    localparam int GRID_EMPTY = -1;
    localparam int N_EDGE_DEF = 96;
    localparam int GRID_N_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int COST_W_DEF = 32;
endpackage

// File: rtl/place_edge_cost.sv
// place_edge_cost: combinational Manhattan / 1-hop length of one edge plus off-grid detection.
// The hop output exists only when PLACE_EVAL_1HOP_EN is defined.
module place_edge_cost
    import place_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int GRID_N = GRID_N_DEF
) (
    input  logic signed [DATA_W-1:0] ax_i,
    input  logic signed [DATA_W-1:0] ay_i,
    input  logic signed [DATA_W-1:0] bx_i,
    input  logic signed [DATA_W-1:0] by_i,
    output logic        [DATA_W-1:0] len_o,
`ifdef PLACE_EVAL_1HOP_EN
    output logic        [DATA_W-1:0] hop_o,
`endif
    output logic                     illegal_o
);
    logic signed [DATA_W-1:0] ddx, ddy;
    logic        [DATA_W-1:0] dx, dy;

    function automatic logic off_grid(input logic signed [DATA_W-1:0] c);
        return c == GRID_EMPTY || c < 0 || c >= GRID_N;
    endfunction

    assign ddx       = ax_i - bx_i;
    assign ddy       = ay_i - by_i;
    assign dx        = ddx[DATA_W-1] ? -ddx : ddx;
    assign dy        = ddy[DATA_W-1] ? -ddy : ddy;
    assign len_o     = dx + dy;
`ifdef PLACE_EVAL_1HOP_EN
    assign hop_o     = ((dx + DATA_W'(1)) >> 1) + ((dy + DATA_W'(1)) >> 1);
`endif
    assign illegal_o = off_grid(ax_i) | off_grid(ay_i) | off_grid(bx_i) | off_grid(by_i);
endmodule

// File: rtl/place_eval.sv
// place_eval: walks the edge list after placement and accumulates wirelength, 1-hop cost and max edge length.
// Define PLACE_EVAL_1HOP_EN to build the 1-hop accumulator; otherwise sum_1hop is tied to 0.
module place_eval
    import place_pkg::*;
#(
    parameter int N_EDGE = N_EDGE_DEF,
    parameter int GRID_N = GRID_N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int COST_W = COST_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_unplaced,
    output logic [DATA_W-1:0] err_edge,
    output logic              edge_re,
    output logic [DATA_W-1:0] edge_addr,
    input  logic [DATA_W-1:0] edge_a,
    input  logic [DATA_W-1:0] edge_b,
    output logic              pos_re,
    output logic [DATA_W-1:0] pos_addr,
    input  logic [DATA_W-1:0] pos_x,
    input  logic [DATA_W-1:0] pos_y,
    output logic [COST_W-1:0] sum,
    output logic [COST_W-1:0] sum_1hop,
    output logic [COST_W-1:0] max_len,
    output logic [31:0]       cycles
);
    state_e            state_q;
    logic [DATA_W-1:0] i_q, ax_q, ay_q, len_q, err_edge_q, edge_addr_q, pos_addr_q, len;
    logic [COST_W-1:0] sum_q, max_q;
    logic [31:0]       cyc_q;
    logic              busy_q, done_q, err_q, edge_re_q, pos_re_q, illegal;
`ifdef PLACE_EVAL_1HOP_EN
    logic [DATA_W-1:0] hop, hop_q;
    logic [COST_W-1:0] hop_sum_q;
`endif

    place_edge_cost #(.DATA_W(DATA_W), .GRID_N(GRID_N)) u_cost (
        .ax_i      (ax_q),
        .ay_i      (ay_q),
        .bx_i      (pos_x),
        .by_i      (pos_y),
        .len_o     (len),
`ifdef PLACE_EVAL_1HOP_EN
        .hop_o     (hop),
`endif
        .illegal_o (illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            ax_q        <= '0;
            ay_q        <= '0;
            len_q       <= '0;
            err_edge_q  <= '0;
            edge_addr_q <= '0;
            pos_addr_q  <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            cyc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            edge_re_q   <= 1'b0;
            pos_re_q    <= 1'b0;
`ifdef PLACE_EVAL_1HOP_EN
            hop_q       <= '0;
            hop_sum_q   <= '0;
`endif
        end else begin
            edge_re_q <= 1'b0;
            pos_re_q  <= 1'b0;
            if (busy_q) cyc_q <= cyc_q + 32'd1;
            case (state_q)
                S_EDGE: begin
                    pos_re_q <= 1'b1;
                    state_q  <= S_PA;
                end
                // edge_a drives pos_addr combinationally this cycle; B's address is held for S_PB
                S_PA: begin
                    pos_re_q   <= 1'b1;
                    pos_addr_q <= edge_b;
                    state_q    <= S_PB;
                end
                S_PB: begin
                    ax_q    <= pos_x;
                    ay_q    <= pos_y;
                    state_q <= S_DIFF;
                end
                S_DIFF: begin
                    len_q <= len;
`ifdef PLACE_EVAL_1HOP_EN
                    hop_q <= hop;
`endif
                    if (illegal) begin
                        state_q    <= ERROR;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= 1'b1;
                        err_edge_q <= i_q;
                    end else begin
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    sum_q <= sum_q + COST_W'(len_q) - COST_W'(1);
`ifdef PLACE_EVAL_1HOP_EN
                    hop_sum_q <= hop_sum_q + COST_W'(hop_q) - COST_W'(1);
`endif
                    if (COST_W'(len_q) > max_q) max_q <= COST_W'(len_q);
                    i_q <= i_q + DATA_W'(1);
                    if (i_q == DATA_W'(N_EDGE - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_EDGE;
                        edge_re_q   <= 1'b1;
                        edge_addr_q <= i_q + DATA_W'(1);
                    end
                end
                default: if (start) begin
                    sum_q       <= '0;
                    max_q       <= '0;
                    cyc_q       <= '0;
                    i_q         <= '0;
                    err_q       <= 1'b0;
                    err_edge_q  <= '0;
`ifdef PLACE_EVAL_1HOP_EN
                    hop_sum_q   <= '0;
`endif
                    done_q      <= N_EDGE == 0;
                    busy_q      <= N_EDGE != 0;
                    edge_re_q   <= N_EDGE != 0;
                    edge_addr_q <= '0;
                    state_q     <= N_EDGE == 0 ? DONE : S_EDGE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_unplaced = err_q;
    assign err_edge     = err_edge_q;
    assign edge_re      = edge_re_q;
    assign edge_addr    = edge_addr_q;
    assign pos_re       = pos_re_q;
    assign pos_addr     = state_q == S_PA ? edge_a : pos_addr_q;
    assign sum          = sum_q;
    assign max_len      = max_q;
    assign cycles       = cyc_q;
`ifdef PLACE_EVAL_1HOP_EN
    assign sum_1hop     = hop_sum_q;
`else
    assign sum_1hop     = '0;
`endif
endmodule

// File: tb/tb_place_eval.sv
// tb_place_eval: scoreboard bench for place_eval with directed test-plan vectors and random placements.
module tb_place_eval;
    localparam int NE = 3, GN = 10, DW = 32, CW = 32, NN = 8;
`ifdef PLACE_EVAL_1HOP_EN
    localparam int V1_HOP = 12;
`else
    localparam int V1_HOP = 0;
`endif

    logic          clk = 1'b0, reset, start;
    logic          busy, done, err_unplaced, edge_re, pos_re;
    logic [DW-1:0] err_edge, edge_addr, pos_addr, edge_a, edge_b, pos_x, pos_y;
    logic [CW-1:0] sum, sum_1hop, max_len;
    logic [31:0]   cycles;

    typedef struct {
        logic [31:0] s, h, m, c, ee;
        logic        e;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   ea_m[NE], eb_m[NE], px_m[NN], py_m[NN];
    int   cnt = 0, tests = 0, fails = 0;
    logic done_prev = 1'b0;

    place_eval #(.N_EDGE(NE), .GRID_N(GN), .DATA_W(DW), .COST_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .err_unplaced(err_unplaced), .err_edge(err_edge), .edge_re(edge_re),
        .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b), .pos_re(pos_re),
        .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y), .sum(sum),
        .sum_1hop(sum_1hop), .max_len(max_len), .cycles(cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    // one-cycle-latency edge ROMs and position RAMs
    always @(posedge clk) begin
        if (edge_re) begin
            edge_a <= ea_m[edge_addr];
            edge_b <= eb_m[edge_addr];
        end
        if (pos_re) begin
            pos_x <= px_m[pos_addr];
            pos_y <= py_m[pos_addr];
        end
    end

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic bit bad(input int c);
        return c < 0 || c >= GN;
    endfunction

    // reference: sum the costs edge by edge, stopping at the first edge touching an off-grid cell
    function automatic exp_t model(input int at0);
        exp_t x;
        int s = 0, h = 0, m = 0;
        x.e = 1'b0;
        x.ee = 0;
        for (int e = 0; e < NE; e++) begin
            int ax = px_m[ea_m[e]], ay = py_m[ea_m[e]];
            int bx = px_m[eb_m[e]], by = py_m[eb_m[e]];
            int dx = ax > bx ? ax - bx : bx - ax;
            int dy = ay > by ? ay - by : by - ay;
            if (bad(ax) || bad(ay) || bad(bx) || bad(by)) begin
                x.e = 1'b1;
                x.ee = e;
                x.c = 5 * e + 4;
                x.at = at0 + 5 * e + 4;
                x.s = s;
                x.h = h;
                x.m = m;
                return x;
            end
            s += dx + dy - 1;
            h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
            if (dx + dy > m) m = dx + dy;
        end
        x.s = s;
        x.h = h;
        x.m = m;
        x.c = 5 * NE;
        x.at = at0 + 5 * NE;
        return x;
    endfunction

    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no completion", cnt);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("sum", sum, x.s);
                check("sum_1hop", sum_1hop, x.h);
                check("max_len", max_len, x.m);
                check("cycles", cycles, x.c);
                check("err_unplaced", 32'(err_unplaced), 32'(x.e));
                check("err_edge", err_edge, x.ee);
                check("done_cycle", cnt, x.at);
                check("busy_at_done", 32'(busy), 0);
            end
        end
        done_prev <= done;
    end

    task automatic set_edge(input int e, input int ax, input int ay, input int bx, input int by);
        ea_m[e] = 2 * e;
        eb_m[e] = 2 * e + 1;
        px_m[2 * e] = ax;
        py_m[2 * e] = ay;
        px_m[2 * e + 1] = bx;
        py_m[2 * e + 1] = by;
    endtask

    task automatic vec1();
        set_edge(0, 0, 0, 3, 4);
        set_edge(1, 2, 2, 2, 3);
        set_edge(2, 9, 9, 0, 0);
    endtask

    task automatic launch();
        exp_t x;
        @(negedge clk);
        start = 1'b1;
        x = model(cnt + 1);
`ifndef PLACE_EVAL_1HOP_EN
        x.h = 0;
`endif
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within 300 cycles, required done");
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] any_out();
        return 32'(|{busy, done, err_unplaced, err_edge, edge_re, edge_addr, pos_re,
                     pos_addr, sum, sum_1hop, max_len, cycles});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", any_out(), 0);
        reset = 1'b0;

        vec1();
        launch();
        wait_idle();
        check("v1_sum", sum, 23);
        check("v1_hop", sum_1hop, V1_HOP);
        check("v1_max", max_len, 18);
        check("v1_cycles", cycles, 15);

        set_edge(1, 2, 2, -1, 5);
        launch();
        wait_idle();
        check("v2_err", 32'(err_unplaced), 1);
        check("v2_err_edge", err_edge, 1);
        check("v2_sum", sum, 6);

        set_edge(1, 10, 0, 2, 3);
        launch();
        wait_idle();
        check("v3_err_edge", err_edge, 1);
        set_edge(1, 9, 0, 2, 3);
        launch();
        wait_idle();
        check("v3_legal", 32'(err_unplaced), 0);

        vec1();
        launch();
        repeat (2) @(negedge clk);
        start = 1'b1;
        check("busy_mid", 32'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        launch();
        repeat (7) @(negedge clk);
        check("pb_strobe", 32'(pos_re), 1);
        reset = 1'b1;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_outs", any_out(), 0);
        end
        reset = 1'b0;
        launch();
        wait_idle();
        check("after_abort_sum", sum, 23);

        for (int r = 0; r < 20; r++) begin
            bit wild = 1'($urandom_range(0, 1));
            for (int n = 0; n < NN; n++) begin
                px_m[n] = wild ? int'($urandom_range(0, 11)) - 1 : int'($urandom_range(0, GN - 1));
                py_m[n] = wild ? int'($urandom_range(0, 11)) - 1 : int'($urandom_range(0, GN - 1));
            end
            for (int e = 0; e < NE; e++) begin
                ea_m[e] = int'($urandom_range(0, NN - 1));
                eb_m[e] = int'($urandom_range(0, NN - 1));
            end
            launch();
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/place_eval.md
# place_eval

Post-placement cost evaluator that sits directly downstream of the placement engine. After placement finishes, it walks the edge list (A/B edge ROMs), fetches both endpoint coordinates from the pos_X/pos_Y RAMs, and accumulates Manhattan wirelength, 1-hop wirelength and maximum edge length. It also flags any edge whose endpoint is unplaced or off-grid. It owns the read ports of the edge ROMs and position RAMs while busy; the placement engine must be idle.

## Interface
- N_EDGE, 96, number of edges evaluated (edge addresses 0..N_EDGE-1)
- GRID_N, 10, grid side length; legal coordinate range is 0..GRID_N-1
- DATA_W, 32, width of memory data, addresses and node ids (signed)
- COST_W, 32, width of cost accumulators
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- start  in  1  begin evaluation; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done rises
- done  out  1  level; high in DONE/ERROR; cleared by next accepted start
- err_unplaced  out  1  an endpoint coordinate was -1 or outside 0..GRID_N-1
- err_edge  out  DATA_W  index of the offending edge (valid with err_unplaced)
- edge_re  out  1  read strobe to both edge ROMs
- edge_addr  out  DATA_W  shared edge ROM address
- edge_a, edge_b  in  DATA_W  node ids; valid one cycle after edge_re
- pos_re  out  1  read strobe to pos_X and pos_Y
- pos_addr  out  DATA_W  shared node address
- pos_x, pos_y  in  DATA_W  signed coordinates; valid one cycle after pos_re
- sum  out  COST_W  Σ(|dx|+|dy|-1)
- sum_1hop  out  COST_W  Σ(ceil(|dx|/2)+ceil(|dy|/2)-1)
- max_len  out  COST_W  max(|dx|+|dy|) over evaluated edges
- cycles  out  32  clock count from accept to done

## Operation
- States: IDLE, S_EDGE, S_PA, S_PB, S_DIFF, S_ACC, DONE, ERROR.
- IDLE with start=1: clear sum, sum_1hop, max_len, cycles, i, err_*, done. Go to S_EDGE, or to DONE if N_EDGE==0.
- S_EDGE: edge_re=1, edge_addr=i → S_PA.
- S_PA: latch a=edge_a, b=edge_b; pos_re=1, pos_addr=edge_a → S_PB.
- S_PB: latch ax=pos_x, ay=pos_y; pos_re=1, pos_addr=b → S_DIFF.
- S_DIFF: latch bx, by; dx=|ax-bx|, dy=|ay-by| (two's-complement negate). If any of ax, ay, bx, by is <0 or ≥GRID_N → ERROR with err_edge=i. Otherwise → S_ACC.
- S_ACC: update sum, sum_1hop and max_len; i<=i+1. Next state is DONE if i==N_EDGE-1, else S_EDGE.
- DONE/ERROR: hold all outputs; start=1 restarts exactly as from IDLE.
- Strobes are single-cycle and are 0 in every other state. Addresses hold their last value.
- Accumulators wrap modulo 2^COST_W with no saturation. A zero-length edge (a==b position) contributes -1, matching the engine's convention.
- start while busy is ignored.

## Timing
- Reset (async): state=IDLE; all outputs 0 (err_edge=0, edge_addr=0, pos_addr=0).
- Memory read latency is exactly 1 cycle; no back-pressure.
- 5 cycles per edge. If start is accepted at cycle t, done rises at t+1+5·N_EDGE and cycles=5·N_EDGE.
- ERROR on edge i: done and err_unplaced rise at t+1+5·i+4. sum holds the partial total of edges 0..i-1.
- Reset mid-run aborts immediately. No memory strobes are issued after reset asserts.

## Configuration
- PLACE_EVAL_1HOP_EN defined: sum_1hop is computed as above.
- PLACE_EVAL_1HOP_EN undefined: no 1-hop logic is built and sum_1hop is tied to 0. All other behaviour and timing are unchanged.

## Structure
- Shared package place_pkg holds:
  - the state enum
  - GRID_EMPTY = -1
  - default N_EDGE/GRID_N/DATA_W constants shared with the placement engine
- Sub-module place_edge_cost (combinational) takes ax, ay, bx, by. It returns dx, dy, len=dx+dy, hop=ceil(dx/2)+ceil(dy/2) and an illegal flag.

## Test plan
- N_EDGE=3. Positions: A0(0,0)-B0(3,4); A1(2,2)-B1(2,3); A2(9,9)-B2(0,0). Expect:
  - sum=6+0+17=23
  - sum_1hop=3+0+9=12
  - max_len=18
  - cycles=15, done at t+16, err_unplaced=0.
- Second edge endpoint at (-1,5) → err_unplaced=1, err_edge=1, sum=6 (edge 0 only), done=1.
- Coordinate (10,0) with GRID_N=10 → error on that edge. Coordinate (9,0) is accepted.
- Pulse start at cycle 4 of a run → ignored; run completes at the original done cycle with unchanged results.
- Assert reset at the 2nd S_PB → all outputs 0 next edge. A new start gives the full correct result from edge 0.
- Build without PLACE_EVAL_1HOP_EN on vector 1 → sum=23, sum_1hop=0, same timing.
